// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C request arbiter: FSM encodings and defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package i2c_pkg;

   // Arbiter FSM states
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARB       = 3'd1,
      START     = 3'd2,
      WAIT_BUSY = 3'd3,
      ADDR      = 3'd4,
      DATA      = 3'd5,
      WAIT_DONE = 3'd6,
      FINISH    = 3'd7
   } state_t;

   // Default bound on cycles spent in any wait state
   localparam int DEF_TIMEOUT = 4095;

   // Idle value of the byte presented to the master (bus released)
   localparam logic [7:0] M_DATA_IDLE = 8'hFF;

endpackage

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or after ptr+1, modulo N_REQ.
// Latency: purely combinational.
// Backpressure: none; valid low when no request is asserted.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [PW-1:0]    idx,
   output logic             valid
);

   logic [PW-1:0] cand;

   // Scan candidates ptr+1, ptr+2, ... and keep the first one requesting
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = PW'((int'(ptr) + k) % N_REQ);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Arbitrates N_REQ requesters onto one I2C master and sequences address/data bytes.
// Latency: m_start 2 cycles after req when idle; done 1 cycle after m_busy falls.
// Backpressure: requesters hold req until done; master paced by m_busy/m_byte_ack with timeout.
module i2c_req_arbiter
   import i2c_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [7*N_REQ-1:0] addr,
   input  logic [N_REQ-1:0]   rw,
   input  logic [8*N_REQ-1:0] wdata,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   done,
   output logic [N_REQ-1:0]   err,
   output logic [7:0]         rdata,
   output logic               m_start,
   output logic [7:0]         m_data,
   input  logic               m_busy,
   input  logic               m_byte_ack,
   input  logic [7:0]         m_rdata,
   output logic               m_abort
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t           state;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    idx;
   logic [6:0]       addr_q;
   logic             rw_q;
   logic [7:0]       wdata_q;
   logic [CW-1:0]    wait_cnt;

   logic [PW-1:0]    pick_idx;
   logic             pick_vld;
   logic [N_REQ-1:0] pick_oh;
   logic [N_REQ-1:0] idx_oh;
   logic [6:0]       pick_addr;
   logic             pick_rw;
   logic [7:0]       pick_wdata;
   logic             in_wait;
   logic             tmo;

   rr_pick #(
      .N_REQ (N_REQ),
      .PW    (PW)
   ) u_rr_pick (
      .req   (req),
      .ptr   (ptr),
      .idx   (pick_idx),
      .valid (pick_vld)
   );

   // Select the winning requester's fields and build one-hot vectors
   always_comb begin
      pick_addr  = '0;
      pick_rw    = 1'b0;
      pick_wdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_idx == PW'(i)) begin
            pick_addr  = addr[i*7 +: 7];
            pick_rw    = rw[i];
            pick_wdata = wdata[i*8 +: 8];
         end
      end
      pick_oh = N_REQ'(1) << pick_idx;
      idx_oh  = N_REQ'(1) << idx;
      in_wait = (state == WAIT_BUSY) || (state == ADDR) ||
                (state == DATA)      || (state == WAIT_DONE);
      tmo     = in_wait && (wait_cnt == CW'(TIMEOUT));
   end

   // Main sequencer: one-cycle strobes default low, counter clears unless a wait state lingers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         gnt      <= '0;
         done     <= '0;
         err      <= '0;
         m_start  <= 1'b0;
         m_abort  <= 1'b0;
         m_data   <= M_DATA_IDLE;
         rdata    <= '0;
         ptr      <= PW'(N_REQ - 1);
         wait_cnt <= '0;
         idx      <= '0;
         addr_q   <= '0;
         rw_q     <= 1'b0;
         wdata_q  <= '0;
      end else begin
         done     <= '0;
         err      <= '0;
         m_start  <= 1'b0;
         m_abort  <= 1'b0;
         wait_cnt <= '0;
         if (tmo) begin
            // Give up: report to the owner, reset the master path, move the pointer on
            err     <= idx_oh;
            done    <= idx_oh;
            m_abort <= 1'b1;
            gnt     <= '0;
            ptr     <= idx;
            state   <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if ((|req) && !m_busy) state <= ARB;
               end
               ARB: begin
                  if (pick_vld) begin
                     idx     <= pick_idx;
                     addr_q  <= pick_addr;
                     rw_q    <= pick_rw;
                     wdata_q <= pick_wdata;
                     gnt     <= pick_oh;
                     m_start <= 1'b1;
                     m_data  <= {pick_addr, pick_rw};
                     state   <= START;
                  end else begin
                     // Request vanished between IDLE and ARB
                     state <= IDLE;
                  end
               end
               START: begin
                  state <= WAIT_BUSY;
               end
               WAIT_BUSY: begin
                  if (m_busy) state <= ADDR;
                  else        wait_cnt <= wait_cnt + CW'(1);
               end
               ADDR: begin
                  if (m_byte_ack) begin
                     if (rw_q) begin
                        state <= WAIT_DONE;
                     end else begin
                        m_data <= wdata_q;
                        state  <= DATA;
                     end
                  end else begin
                     wait_cnt <= wait_cnt + CW'(1);
                  end
               end
               DATA: begin
                  if (m_byte_ack) state <= WAIT_DONE;
                  else            wait_cnt <= wait_cnt + CW'(1);
               end
               WAIT_DONE: begin
                  if (!m_busy) begin
                     done  <= idx_oh;
                     gnt   <= '0;
                     ptr   <= idx;
                     if (rw_q) rdata <= m_rdata;
                     state <= FINISH;
                  end else begin
                     wait_cnt <= wait_cnt + CW'(1);
                  end
               end
               FINISH: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomized scoreboard bench for i2c_req_arbiter with a behavioural I2C master.
// Latency: checks req->m_start, busy-fall->done and timeout timing.
// Backpressure: master model randomizes busy/ack pacing and can hang to force timeouts.
module tb_i2c_req_arbiter;

   localparam int N   = 4;
   localparam int TMO = 30;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N-1:0]   req = '0;
   logic [7*N-1:0] addr = '0;
   logic [N-1:0]   rw = '0;
   logic [8*N-1:0] wdata = '0;
   logic [N-1:0]   gnt, done, err;
   logic [7:0]     rdata, m_data;
   logic           m_start, m_abort;
   logic           m_busy = 1'b0;
   logic           m_byte_ack = 1'b0;
   logic [7:0]     m_rdata = 8'h00;

   i2c_req_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .req(req), .addr(addr), .rw(rw), .wdata(wdata),
      .gnt(gnt), .done(done), .err(err), .rdata(rdata), .m_start(m_start),
      .m_data(m_data), .m_busy(m_busy), .m_byte_ack(m_byte_ack),
      .m_rdata(m_rdata), .m_abort(m_abort)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [6:0] addr;
      logic       rw;
      logic [7:0] wdata;
      logic [7:0] rd;
      bit         hang;
   } txn_t;

   typedef struct {
      int         idx;
      logic       rw;
      logic [6:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
      bit         err;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] rd_q[$];
   bit         hang_q[$];
   txn_t       tx[N][8];
   int         tcnt[N];
   int         thead[N];
   int         launch_id = 0;
   int         mptr = N - 1;
   logic [7:0] mrdata = 8'h00;
   int         n_chk = 0;
   int         n_fail = 0;
   int         req_cyc = 0;
   bit         lat_en = 1'b0;
   int         addr_hold = -1;

   function automatic logic [N-1:0] oh(input int i);
      return N'(1) << i;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // ---------------- requester drivers ----------------
   int seen_launch = 0;

   task automatic present(input int i);
      req[i]           = 1'b1;
      addr[i*7 +: 7]   = tx[i][thead[i]].addr;
      rw[i]            = tx[i][thead[i]].rw;
      wdata[i*8 +: 8]  = tx[i][thead[i]].wdata;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            req = '0;
            seen_launch = launch_id;
         end else if (launch_id != seen_launch) begin
            seen_launch = launch_id;
            for (int i = 0; i < N; i++) begin
               thead[i] = 0;
               if (tcnt[i] > 0) present(i);
            end
            req_cyc = cyc;
         end else begin
            for (int i = 0; i < N; i++) begin
               if (done[i]) begin
                  thead[i]++;
                  if (thead[i] < tcnt[i]) present(i);
                  else req[i] = 1'b0;
               end else if (gnt[i]) begin
                  // Latched fields must not follow these changes
                  addr[i*7 +: 7]  = 7'($urandom);
                  rw[i]           = 1'($urandom);
                  wdata[i*8 +: 8] = 8'($urandom);
                  req[i]          = 1'($urandom);
               end
            end
         end
      end
   end

   // ---------------- I2C master model ----------------
   typedef enum int {M_IDLE, M_DELAY, M_ADDR, M_DATA, M_TAIL, M_HANG} mst_t;
   mst_t       mst = M_IDLE;
   int         mcnt = 0;
   bit         hg;
   logic [7:0] obs_addr = 8'h00, obs_data = 8'h00, obs_tail = 8'h00;
   int         fall_cyc = 0;

   initial begin
      forever begin
         @(negedge clk);
         m_byte_ack = 1'b0;
         if (!rst) begin
            mst    = M_IDLE;
            m_busy = 1'b0;
         end else begin
            case (mst)
               M_IDLE: if (m_start) begin
                  m_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
                  hg      = (hang_q.size() > 0) ? hang_q.pop_front() : 1'b0;
                  mcnt    = $urandom_range(3, 0);
                  mst     = hg ? M_HANG : M_DELAY;
               end
               M_DELAY: if (mcnt == 0) begin
                  m_busy = 1'b1;
                  mcnt   = (addr_hold >= 0) ? addr_hold : $urandom_range(3, 0);
                  mst    = M_ADDR;
               end else begin
                  mcnt--;
                  m_byte_ack = ($urandom_range(3, 0) == 0);
               end
               M_ADDR: if (mcnt == 0) begin
                  m_byte_ack = 1'b1;
                  obs_addr   = m_data;
                  mcnt       = $urandom_range(3, 0);
                  mst        = m_data[0] ? M_TAIL : M_DATA;
               end else mcnt--;
               M_DATA: if (mcnt == 0) begin
                  m_byte_ack = 1'b1;
                  obs_data   = m_data;
                  mcnt       = $urandom_range(3, 0);
                  mst        = M_TAIL;
               end else mcnt--;
               M_TAIL: if (mcnt == 0) begin
                  m_busy   = 1'b0;
                  obs_tail = m_data;
                  fall_cyc = cyc;
                  mst      = M_IDLE;
               end else begin
                  mcnt--;
                  m_byte_ack = ($urandom_range(3, 0) == 0);
               end
               M_HANG: if (m_abort) mst = M_IDLE;
               default: mst = M_IDLE;
            endcase
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int   start_cyc = 0;
   exp_t e;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            if (m_start) begin
               start_cyc = cyc;
               if (exp_q.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
               else chk("gnt_at_start", 32'(gnt), 32'(oh(exp_q[0].idx)));
               if (lat_en) begin
                  chk("req_to_start_latency", cyc - req_cyc, 32'd2);
                  lat_en = 1'b0;
               end
            end
            if (done != '0) begin
               if (exp_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
               else begin
                  e = exp_q.pop_front();
                  chk("done_onehot", 32'(done), 32'(oh(e.idx)));
                  chk("err", 32'(err), e.err ? 32'(oh(e.idx)) : 32'd0);
                  chk("m_abort", 32'(m_abort), 32'(e.err));
                  chk("gnt_cleared", 32'(gnt), 32'd0);
                  chk("rdata", 32'(rdata), 32'(e.rdata));
                  if (e.err) chk("timeout_cycle", cyc - start_cyc, TMO + 2);
                  else begin
                     chk("addr_byte", 32'(obs_addr), 32'({e.addr, e.rw}));
                     if (!e.rw) chk("data_byte", 32'(obs_data), 32'(e.wdata));
                     chk("tail_byte", 32'(obs_tail), e.rw ? 32'({e.addr, 1'b1}) : 32'(e.wdata));
                     chk("done_after_busy_fall", cyc - fall_cyc, 32'd1);
                  end
               end
            end else if (err != '0 || m_abort) begin
               chk("err_without_done", 32'({err, m_abort}), 32'd0);
            end
         end
      end
   end

   // ---------------- reference model and phase control ----------------
   // Round-robin order over all queued transactions, all requesters present at once
   task automatic plan();
      int   rem[N];
      int   pos[N];
      int   pick;
      bit   any;
      txn_t t;
      exp_t x;
      for (int i = 0; i < N; i++) begin
         rem[i] = tcnt[i];
         pos[i] = 0;
      end
      any = 1'b1;
      while (any) begin
         pick = -1;
         for (int k = 1; k <= N; k++)
            if (pick < 0 && rem[(mptr + k) % N] > 0) pick = (mptr + k) % N;
         if (pick < 0) any = 1'b0;
         else begin
            t       = tx[pick][pos[pick]];
            x.idx   = pick;
            x.rw    = t.rw;
            x.addr  = t.addr;
            x.wdata = t.wdata;
            x.err   = t.hang;
            if (!t.hang && t.rw) mrdata = t.rd;
            x.rdata = mrdata;
            exp_q.push_back(x);
            rd_q.push_back(t.rd);
            hang_q.push_back(t.hang);
            mptr = pick;
            rem[pick]--;
            pos[pick]++;
         end
      end
   endtask

   task automatic launch();
      @(negedge clk);
      launch_id++;
   endtask

   task automatic drain(input int budget);
      int w = 0;
      while (exp_q.size() != 0 && w < budget) begin
         @(negedge clk);
         w++;
      end
      if (exp_q.size() != 0) begin
         chk("phase_drained", exp_q.size(), 32'd0);
         exp_q.delete();
         rd_q.delete();
         hang_q.delete();
      end
      repeat (4) @(negedge clk);
      for (int i = 0; i < N; i++) tcnt[i] = 0;
   endtask

   task automatic rand_txn(input int i, input int k);
      tx[i][k] = '{addr: 7'($urandom), rw: 1'($urandom), wdata: 8'($urandom),
                   rd: 8'($urandom), hang: 1'b0};
   endtask

   initial begin
      #6000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int j;
      for (int i = 0; i < N; i++) tcnt[i] = 0;

      // Reset state
      @(negedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_m_start", 32'(m_start), 32'd0);
      chk("rst_m_abort", 32'(m_abort), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'hFF);
      chk("rst_rdata", 32'(rdata), 32'd0);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);

      // Fairness: all four requesting, requester 0 twice -> 0,1,2,3,0
      for (int i = 0; i < N; i++) begin
         tcnt[i] = (i == 0) ? 2 : 1;
         for (int k = 0; k < tcnt[i]; k++) rand_txn(i, k);
      end
      plan();
      launch();
      drain(2000);

      // Single write with latency check
      tcnt[0] = 1;
      tx[0][0] = '{addr: 7'h50, rw: 1'b0, wdata: 8'hA5, rd: 8'h77, hang: 1'b0};
      plan();
      lat_en = 1'b1;
      launch();
      drain(500);

      // Single read
      tcnt[2] = 1;
      tx[2][0] = '{addr: 7'h51, rw: 1'b1, wdata: 8'h00, rd: 8'h3C, hang: 1'b0};
      plan();
      launch();
      drain(500);

      // Random mixes of requesters and transactions
      for (int p = 0; p < 8; p++) begin
         w = $urandom_range(15, 1);
         for (int i = 0; i < N; i++) begin
            if (w[i]) begin
               tcnt[i] = $urandom_range(3, 1);
               for (int k = 0; k < tcnt[i]; k++) rand_txn(i, k);
            end
         end
         plan();
         launch();
         drain(3000);
      end

      // Timeout on the next requester in line, the one after it served normally
      j = (mptr + 1) % N;
      tcnt[j] = 1;
      rand_txn(j, 0);
      tx[j][0].hang = 1'b1;
      tcnt[(j + 1) % N] = 1;
      rand_txn((j + 1) % N, 0);
      plan();
      launch();
      drain(1000);

      // Reset while the master is in its address phase
      tcnt[1] = 1;
      tx[1][0] = '{addr: 7'h22, rw: 1'b0, wdata: 8'h5A, rd: 8'h00, hang: 1'b0};
      addr_hold = 6;
      plan();
      launch();
      w = 0;
      while (mst != M_ADDR && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("reached_addr_phase", 32'(mst == M_ADDR), 32'd1);
      @(negedge clk);
      #2 rst = 1'b0;
      exp_q.delete();
      rd_q.delete();
      hang_q.delete();
      addr_hold = -1;
      for (int i = 0; i < N; i++) tcnt[i] = 0;
      #1;
      chk("midrst_gnt", 32'(gnt), 32'd0);
      chk("midrst_m_data", 32'(m_data), 32'hFF);
      chk("midrst_done", 32'(done), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("midrst_no_done", 32'(done), 32'd0);
      end
      #2 rst = 1'b1;
      mptr   = N - 1;
      mrdata = 8'h00;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post_rst_idle_gnt", 32'(gnt), 32'd0);
      end

      // Fresh request completes normally after reset
      tcnt[3] = 1;
      rand_txn(3, 0);
      plan();
      launch();
      drain(500);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
